// File: rtl/icache_if.sv
// IF-stage fetch port and mem_ctrl instruction port of the instruction cache.
// slave = cache side, master = pipeline / memory controller side.
interface icache_if;
  logic        is_jump;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_rdy;
  logic        inst_needed;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_rdy;
  logic        inst_busy;

  modport slave (
    input  is_jump, if_req, if_addr, inst_data, inst_rdy, inst_busy,
    output if_data, if_rdy, inst_needed, inst_addr
  );

  modport master (
    output is_jump, if_req, if_addr, inst_data, inst_rdy, inst_busy,
    input  if_data, if_rdy, inst_needed, inst_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Latency: hit 1 cycle, miss = mem_ctrl latency + 1; one response per 2 cycles at most.
// Backpressure: IF holds if_req until the if_rdy pulse; is_jump abandons any pending miss.
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input logic      clk,
  input logic      rst,
  icache_if.slave  bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  state_t                state;
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_BITS-1:0]   tag_q  [ENTRIES];
  logic [31:0]           data_q [ENTRIES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_bits;

  assign req_idx  = bus.if_addr[INDEX_BITS+1:2];
  assign req_tag  = bus.if_addr[31:INDEX_BITS+2];
  assign fill_idx = bus.inst_addr[INDEX_BITS+1:2];
  assign fill_tag = bus.inst_addr[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_en  = (state == MISS) && bus.inst_rdy && !bus.is_jump && !rst;

  // Drops in the inst_rdy cycle itself so mem_ctrl never sees a second request.
  assign bus.inst_needed = (state == MISS) && !bus.inst_rdy && !bus.is_jump && !rst;

  assign unused_bits = ^{bus.inst_busy, bus.if_addr[1:0], bus.inst_addr[1:0]};

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.inst_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid_q       <= '0;
      bus.if_rdy    <= 1'b0;
      bus.if_data   <= '0;
      bus.inst_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req && !bus.is_jump) begin
            if (hit) begin
              bus.if_data <= data_q[req_idx];
              bus.if_rdy  <= 1'b1;
              state       <= RESP;
            end else begin
              bus.inst_addr <= {bus.if_addr[31:2], 2'b00};
              state         <= MISS;
            end
          end
        end
        MISS: begin
          if (bus.is_jump) begin
            state <= IDLE;
          end else if (bus.inst_rdy) begin
            valid_q[fill_idx] <= 1'b1;
            bus.if_data       <= bus.inst_data;
            bus.if_rdy        <= 1'b1;
            state             <= RESP;
          end
        end
        RESP: begin
          // The held request is deliberately ignored here so it is not serviced twice.
          bus.if_rdy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and the memory controller.
- Serves IF fetch requests from an on-chip array.
- On a miss, drives the controller's instruction port (inst_needed/inst_addr), waits for inst_rdy, fills the line and returns the word.
- Line size is one 32-bit instruction. A jump flush abandons any in-flight miss, matching the controller's own is_jump reset.

Parameters:
- INDEX_BITS, 7, log2 of entry count (128 entries); index = addr[INDEX_BITS+1:2].
- TAG_BITS, 32-INDEX_BITS-2, tag = addr[31:INDEX_BITS+2].

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- is_jump  in  1  pipeline flush; squashes pending request/response.
- if_req  in  1  IF fetch request; held with if_addr stable until if_rdy.
- if_addr  in  32  fetch byte address, word aligned (bits [1:0] ignored).
- if_data  out  32  fetched instruction, valid when if_rdy=1.
- if_rdy  out  1  one-cycle pulse: if_data valid.
- inst_needed  out  1  request to mem_ctrl (combinational, see below).
- inst_addr  out  32  miss address to mem_ctrl, word aligned.
- inst_data  in  32  word from mem_ctrl.
- inst_rdy  in  1  mem_ctrl completion pulse.
- inst_busy  in  1  mem_ctrl busy; informational only, not used for control.

Behaviour:
- Storage: valid[2^INDEX_BITS], tag array, data array; registered state; lookup is combinational from if_addr.
- Reset (rst=1 at clk edge):
  - All valid bits cleared; state=IDLE.
  - if_rdy=0, if_data=0, inst_addr=0.
  - inst_needed=0 during reset and the cycle after.
  - Reset mid-miss abandons the miss with no fill.
- States: IDLE, MISS, RESP.
- IDLE:
  - if_req=1, is_jump=0, hit (valid & tag match): if_data<=array word, if_rdy<=1, ->RESP. Hit latency: if_rdy in the cycle after the request is first seen.
  - if_req=1, is_jump=0, miss: inst_addr<={if_addr[31:2],2'b00}, ->MISS.
  - if_req=0 or is_jump=1: stay IDLE.
- MISS:
  - inst_needed = (state==MISS) & ~inst_rdy & ~is_jump. It drops in the same cycle inst_rdy is seen, so mem_ctrl does not restart a transfer.
  - inst_addr is held constant throughout.
  - inst_rdy=1 and is_jump=0: write valid=1, tag and data at the inst_addr index; if_data<=inst_data; if_rdy<=1; ->RESP. Miss latency = mem_ctrl latency + 1 cycle.
  - is_jump=1 (with or without inst_rdy): no fill, no if_rdy, ->IDLE.
- RESP:
  - if_rdy<=0; ->IDLE unconditionally.
  - The request is ignored this cycle, so a held if_req is not re-serviced. Max throughput is one hit per 2 cycles.
  - is_jump in RESP: if_rdy is still already asserted this cycle; IF must discard it.
- if_rdy is never asserted in two consecutive cycles; if_data holds its value until the next if_rdy.
- Same-cycle fill and request cannot occur (requests are only accepted in IDLE).
- Index aliasing: a fill overwrites the entry unconditionally (direct-mapped replacement).
- Target: ~150-250 lines of RTL.

Test Plan:
- Cold miss: reset, if_req=1 with if_addr=0x00000010; mem_ctrl model returns inst_data=0x00A00093 after 5 cycles -> inst_needed=1 with inst_addr=0x10 until the inst_rdy cycle, then if_rdy=1 with if_data=0x00A00093 one cycle later.
- Hit after fill: request 0x10 again -> inst_needed stays 0; if_rdy=1, if_data=0x00A00093 in the next cycle; back-to-back held if_req yields if_rdy every 2nd cycle.
- Conflict: fill 0x10 (0x11111111), then 0x210 (same index at INDEX_BITS=7, data 0x22222222), then 0x10 -> third access misses and refetches 0x11111111.
- Jump mid-miss: miss on 0x40, pulse is_jump 2 cycles in -> inst_needed=0 that cycle, no if_rdy; a later request to 0x40 misses again (no stale fill).
- Jump coincident with inst_rdy on a miss for 0x80 -> no if_rdy and valid[index of 0x80] stays 0.
- Reset mid-miss and after fills: valid lines present, rst=1 for 1 cycle -> all outputs 0; the next request to a previously cached address misses.
